// File: rtl/ball_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ball_pkg
// Description : Shared types and keycode constants for ball movement control.
// Revision    : 1.0 - initial release
// ============================================================================
package ball_pkg;

  typedef enum logic [2:0] {
    NONE  = 3'd0,
    LEFT  = 3'd1,
    RIGHT = 3'd2,
    UP    = 3'd3,
    DOWN  = 3'd4
  } dir_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EVAL   = 2'd1,
    COMMIT = 2'd2
  } move_state_t;

  localparam logic [7:0] KEY_A = 8'h04;
  localparam logic [7:0] KEY_D = 8'h07;
  localparam logic [7:0] KEY_S = 8'h16;
  localparam logic [7:0] KEY_W = 8'h1A;

endpackage
`default_nettype wire

// File: rtl/key_dir_decode.sv
`default_nettype none
// ============================================================================
// Module      : key_dir_decode
// Description : Combinational HID keycode to movement direction mapping.
// Revision    : 1.0 - initial release
// ============================================================================
module key_dir_decode
  import ball_pkg::*;
(
  input  logic [7:0] keycode,
  output dir_t       dir
);

  always_comb begin
    dir = NONE;
    case (keycode)
      KEY_A:   dir = LEFT;
      KEY_D:   dir = RIGHT;
      KEY_S:   dir = DOWN;
      KEY_W:   dir = UP;
      default: dir = NONE;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/ball_move_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ball_move_ctrl
// Description : Per-frame keyboard-driven ball movement with bounds clamping.
// Revision    : 1.0 - initial release
// ============================================================================
module ball_move_ctrl
  import ball_pkg::*;
#(
  parameter int X_START         = 320,
  parameter int Y_START         = 240,
  parameter int X_MIN           = 0,
  parameter int X_MAX           = 479,
  parameter int Y_MIN           = 0,
  parameter int Y_MAX           = 479,
  parameter int SIZE            = 10,
  parameter int STEP            = 1,
  parameter int FRAMES_PER_STEP = 1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic [7:0] keycode,
  output logic [9:0] BallX,
  output logic [9:0] BallY,
  output logic [9:0] BallS,
  output dir_t       dir,
  output logic       blocked,
  output logic       step_done
);

  localparam logic        [7:0]  c_frame_last = 8'(FRAMES_PER_STEP - 1);
  localparam logic signed [11:0] c_step       = 12'(STEP);
  localparam logic signed [11:0] c_x_lo       = 12'(X_MIN + SIZE);
  localparam logic signed [11:0] c_x_hi       = 12'(X_MAX - SIZE);
  localparam logic signed [11:0] c_y_lo       = 12'(Y_MIN + SIZE);
  localparam logic signed [11:0] c_y_hi       = 12'(Y_MAX - SIZE);

  move_state_t              r_state, w_state_next;
  logic        [7:0]        r_frame_cnt;
  dir_t                     r_dir, w_key_dir;
  logic        [9:0]        r_cand_x, r_cand_y;
  logic                     r_clamp;
  logic        [9:0]        r_ball_x, r_ball_y;
  logic                     r_blocked, r_step_done;

  logic                     w_tick_accept, w_step_start;
  logic                     w_latch_dir, w_load_cand, w_commit;
  logic signed [11:0]       w_pos_x, w_pos_y, w_try_x, w_try_y, w_next_x, w_next_y;
  logic                     w_clamp_x, w_clamp_y;
  logic                     w_unused_hi;

  key_dir_decode u_key_dir_decode (
    .keycode (keycode),
    .dir     (w_key_dir)
  );

  // Ticks outside IDLE are dropped entirely, including the divider.
  assign w_tick_accept = frame_tick && (r_state == IDLE);
  assign w_step_start  = w_tick_accept && (r_frame_cnt == c_frame_last);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_step_start) w_state_next = EVAL;
      EVAL:    w_state_next = COMMIT;
      COMMIT:  w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_latch_dir = 1'b0;
    w_load_cand = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      IDLE:    w_latch_dir = w_step_start;
      EVAL:    w_load_cand = 1'b1;
      COMMIT:  w_commit    = 1'b1;
      default: ;
    endcase
  end

  // Signed 12-bit candidate so a step below zero cannot wrap past the clamp.
  always_comb begin
    w_pos_x = signed'({2'b00, r_ball_x});
    w_pos_y = signed'({2'b00, r_ball_y});
    w_try_x = w_pos_x;
    w_try_y = w_pos_y;
    case (r_dir)
      LEFT:    w_try_x = w_pos_x - c_step;
      RIGHT:   w_try_x = w_pos_x + c_step;
      UP:      w_try_y = w_pos_y - c_step;
      DOWN:    w_try_y = w_pos_y + c_step;
      default: ;
    endcase

    w_next_x  = w_try_x;
    w_clamp_x = 1'b0;
    if ((r_dir == LEFT) || (r_dir == RIGHT)) begin
      if (w_try_x < c_x_lo) begin
        w_next_x  = c_x_lo;
        w_clamp_x = 1'b1;
      end else if (w_try_x > c_x_hi) begin
        w_next_x  = c_x_hi;
        w_clamp_x = 1'b1;
      end
    end

    w_next_y  = w_try_y;
    w_clamp_y = 1'b0;
    if ((r_dir == UP) || (r_dir == DOWN)) begin
      if (w_try_y < c_y_lo) begin
        w_next_y  = c_y_lo;
        w_clamp_y = 1'b1;
      end else if (w_try_y > c_y_hi) begin
        w_next_y  = c_y_hi;
        w_clamp_y = 1'b1;
      end
    end
  end

  assign w_unused_hi = ^{w_next_x[11:10], w_next_y[11:10]};

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_frame_cnt <= 8'd0;
      r_dir       <= NONE;
      r_cand_x    <= 10'(X_START);
      r_cand_y    <= 10'(Y_START);
      r_clamp     <= 1'b0;
      r_ball_x    <= 10'(X_START);
      r_ball_y    <= 10'(Y_START);
      r_blocked   <= 1'b0;
      r_step_done <= 1'b0;
    end else begin
      if (w_tick_accept) begin
        r_frame_cnt <= w_step_start ? 8'd0 : r_frame_cnt + 8'd1;
      end
      if (w_latch_dir) begin
        r_dir <= w_key_dir;
      end
      if (w_load_cand) begin
        r_cand_x <= w_next_x[9:0];
        r_cand_y <= w_next_y[9:0];
        r_clamp  <= w_clamp_x | w_clamp_y;
      end
      r_step_done <= w_commit;
      if (w_commit) begin
        r_ball_x  <= r_cand_x;
        r_ball_y  <= r_cand_y;
        r_blocked <= r_clamp;
      end
    end
  end

  assign BallX     = r_ball_x;
  assign BallY     = r_ball_y;
  assign BallS     = 10'(SIZE);
  assign dir       = r_dir;
  assign blocked   = r_blocked;
  assign step_done = r_step_done;

endmodule
`default_nettype wire

// File: tb/tb_ball_move_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ball_move_ctrl
// Description : Self-checking bench for ball_move_ctrl with a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ball_move_ctrl;

  localparam int XS  [3] = '{320, 12, 320};
  localparam int FPS [3] = '{1, 1, 4};
  localparam int LO      = 10;
  localparam int HI      = 469;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick [3];
  logic [7:0] key  [3];
  logic [9:0] bx [3];
  logic [9:0] by [3];
  logic [9:0] bs [3];
  logic [2:0] dr [3];
  logic       blk [3];
  logic       sd  [3];

  int n_pass  = 0;
  int n_total = 0;

  int         mx [3];
  int         my [3];
  int         mcnt [3];
  logic [2:0] mdir [3];
  logic       mblk [3];
  int         pulses [3];

  always #5 clk = ~clk;

  ball_move_ctrl #(.FRAMES_PER_STEP(1)) u_dut0 (
    .Clk(clk), .Reset(rst), .frame_tick(tick[0]), .keycode(key[0]),
    .BallX(bx[0]), .BallY(by[0]), .BallS(bs[0]), .dir(dr[0]),
    .blocked(blk[0]), .step_done(sd[0])
  );

  ball_move_ctrl #(.X_START(12)) u_dut1 (
    .Clk(clk), .Reset(rst), .frame_tick(tick[1]), .keycode(key[1]),
    .BallX(bx[1]), .BallY(by[1]), .BallS(bs[1]), .dir(dr[1]),
    .blocked(blk[1]), .step_done(sd[1])
  );

  ball_move_ctrl #(.FRAMES_PER_STEP(4)) u_dut2 (
    .Clk(clk), .Reset(rst), .frame_tick(tick[2]), .keycode(key[2]),
    .BallX(bx[2]), .BallY(by[2]), .BallS(bs[2]), .dir(dr[2]),
    .blocked(blk[2]), .step_done(sd[2])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Movement rules: one axis per keycode, one pixel per step, NONE otherwise.
  function automatic void key_model(input logic [7:0] k, output int dx, output int dy,
                                    output logic [2:0] d);
    dx = 0; dy = 0; d = 3'd0;
    case (k)
      8'h04:   begin dx = -1; d = 3'd1; end
      8'h07:   begin dx =  1; d = 3'd2; end
      8'h1A:   begin dy = -1; d = 3'd3; end
      8'h16:   begin dy =  1; d = 3'd4; end
      default: ;
    endcase
  endfunction

  function automatic int clampf(input int v, output logic c);
    c = 1'b0;
    if (v < LO) begin c = 1'b1; return LO; end
    if (v > HI) begin c = 1'b1; return HI; end
    return v;
  endfunction

  task automatic reset_models();
    for (int i = 0; i < 3; i++) begin
      mx[i] = XS[i]; my[i] = 240; mcnt[i] = 0; mdir[i] = 3'd0; mblk[i] = 1'b0;
    end
  endtask

  task automatic clk1();
    @(posedge clk); #1;
  endtask

  // One tick on DUT i, then observe the 3-cycle update window.
  task automatic step(input int i, input logic [7:0] k, input logic [7:0] k_late,
                      input bit extra);
    bit         qual;
    int         dx, dy;
    logic [2:0] d;
    logic       c;
    key[i] = k; tick[i] = 1'b1;
    clk1();
    tick[i] = 1'b0;
    qual    = (mcnt[i] == FPS[i] - 1);
    mcnt[i] = qual ? 0 : mcnt[i] + 1;
    key[i]  = k_late;
    if (extra && qual) tick[i] = 1'b1;
    clk1();
    tick[i] = 1'b0;
    check($sformatf("d%0d_early_sd", i), sd[i], 0);
    check($sformatf("d%0d_early_x", i), bx[i], mx[i]);
    clk1();
    if (qual) begin
      key_model(k, dx, dy, d);
      mdir[i] = d;
      c = 1'b0;
      if (dx != 0)      mx[i] = clampf(mx[i] + dx, c);
      else if (dy != 0) my[i] = clampf(my[i] + dy, c);
      mblk[i] = c;
    end
    pulses[i] += int'(sd[i]);
    check($sformatf("d%0d_sd", i), sd[i], qual);
    check($sformatf("d%0d_x", i), bx[i], mx[i]);
    check($sformatf("d%0d_y", i), by[i], my[i]);
    check($sformatf("d%0d_blocked", i), blk[i], mblk[i]);
    check($sformatf("d%0d_dir", i), dr[i], mdir[i]);
    clk1();
    check($sformatf("d%0d_sd_width", i), sd[i], 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] k;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick[i] = 1'b0; key[i] = 8'h00; pulses[i] = 0;
    end
    reset_models();
    clk1(); clk1();
    rst = 1'b0;

    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst%0d_x", i), bx[i], XS[i]);
      check($sformatf("rst%0d_y", i), by[i], 240);
      check($sformatf("rst%0d_s", i), bs[i], 10);
      check($sformatf("rst%0d_dir", i), dr[i], 0);
      check($sformatf("rst%0d_blk", i), blk[i], 0);
      check($sformatf("rst%0d_sd", i), sd[i], 0);
    end

    repeat (5) step(0, 8'h00, 8'h00, 1'b0);
    check("idle_pulses", pulses[0], 5);
    check("idle_x", bx[0], 320);
    check("idle_y", by[0], 240);

    repeat (10) step(0, 8'h07, 8'h07, 1'b0);
    check("right10_x", bx[0], 330);

    repeat (4) step(1, 8'h04, 8'h04, 1'b0);
    check("left_bound_x", bx[1], 10);
    check("left_bound_blk", blk[1], 1);

    repeat (8) step(2, 8'h1A, 8'h1A, 1'b0);
    check("div4_pulses", pulses[2], 2);
    check("div4_y", by[2], 238);

    step(0, 8'h16, 8'h04, 1'b1);
    check("late_key_y", by[0], 241);
    check("late_key_x", bx[0], 330);

    repeat (3) step(2, 8'h07, 8'h07, 1'b0);
    step(2, 8'h16, 8'h04, 1'b1);
    repeat (4) step(2, 8'h07, 8'h07, 1'b0);
    check("drop_pulses", pulses[2], 4);

    repeat (145) step(0, 8'h07, 8'h07, 1'b0);
    check("right_bound_x", bx[0], 469);
    check("right_bound_blk", blk[0], 1);

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 4))
        0:       k = 8'h04;
        1:       k = 8'h07;
        2:       k = 8'h16;
        3:       k = 8'h1A;
        default: k = 8'($urandom);
      endcase
      step(int'($urandom_range(0, 2)), k, 8'($urandom), bit'($urandom_range(0, 1)));
    end

    // Reset landing during COMMIT aborts the step.
    key[0] = 8'h07; tick[0] = 1'b1;
    clk1();
    tick[0] = 1'b0;
    clk1();
    rst = 1'b1;
    clk1();
    rst = 1'b0;
    reset_models();
    check("rst_commit_sd", sd[0], 0);
    check("rst_commit_x", bx[0], 320);
    check("rst_commit_y", by[0], 240);
    check("rst_commit_dir", dr[0], 0);
    check("rst_commit_blk", blk[0], 0);
    clk1();
    check("rst_commit_sd_late", sd[0], 0);

    rst = 1'b1; tick[0] = 1'b1; key[0] = 8'h07;
    clk1();
    rst = 1'b0; tick[0] = 1'b0;
    for (int n = 0; n < 4; n++) begin
      check("rst_tick_sd", sd[0], 0);
      check("rst_tick_x", bx[0], 320);
      clk1();
    end
    step(0, 8'h07, 8'h07, 1'b0);
    repeat (4) step(2, 8'h04, 8'h04, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ball_move_ctrl.md
# ball_move_ctrl

Controller that sequences keyboard-driven movement of the ball sprite. Once per video frame it samples the current keycode, turns it into a direction, checks the candidate position against the playfield bounds and commits a clamped position update. It sits between the USB keyboard keycode register and the VGA color mapper, which consumes `BallX`/`BallY`/`BallS`. It replaces ad-hoc per-frame position arithmetic with one sequenced, bounds-safe update path.

## Interface
Parameters:
- `X_START`, default 320: reset X position (ball center).
- `Y_START`, default 240: reset Y position.
- `X_MIN`, default 0: leftmost legal pixel.
- `X_MAX`, default 479: rightmost legal pixel.
- `Y_MIN`, default 0: topmost legal pixel.
- `Y_MAX`, default 479: bottommost legal pixel.
- `SIZE`, default 10: ball half-extent in pixels.
- `STEP`, default 1: pixels moved per committed step.
- `FRAMES_PER_STEP`, default 1: number of frame ticks per step attempt, range 1..255.

Ports:
- `Clk`, in, 1: the single clock.
- `Reset`, in, 1: synchronous, active-high reset.
- `frame_tick`, in, 1: one-`Clk` pulse per frame (vsync edge, already synchronized).
- `keycode`, in, 8: current HID keycode.
- `BallX`, out, 10: committed center X.
- `BallY`, out, 10: committed center Y.
- `BallS`, out, 10: constant `SIZE`.
- `dir`, out, 3: latched direction (`dir_t`).
- `blocked`, out, 1: last step attempt was clamped at a bound.
- `step_done`, out, 1: one-cycle pulse when a position commit occurs.

## Operation
- Key decode: `0x04` gives LEFT, `0x07` RIGHT, `0x16` DOWN, `0x1A` UP. Any other value gives NONE.
- Frame divider: an 8-bit `frame_cnt` increments on each accepted `frame_tick`. When `frame_cnt == FRAMES_PER_STEP-1`, the tick starts a step attempt and `frame_cnt` returns to 0.
- FSM states are IDLE, EVAL and COMMIT.
  - IDLE: a qualifying tick latches the decoded keycode into `dir` and moves to EVAL. A non-qualifying tick only advances `frame_cnt`.
  - EVAL: computes the candidate position into a registered candidate (`cand_x`, `cand_y`) and a registered `clamp` flag, then moves to COMMIT. With `dir == NONE` the candidate equals the current position.
  - COMMIT: writes the candidate to `BallX`/`BallY`, writes `clamp` to `blocked`, pulses `step_done`, and returns to IDLE.
- Arithmetic is done in 12-bit signed, so LEFT/UP near 0 cannot wrap.
  - The bounds are `lo = MIN+SIZE` and `hi = MAX-SIZE`.
  - If `cand < lo`, the candidate becomes `lo` and `clamp = 1`.
  - If `cand > hi`, the candidate becomes `hi` and `clamp = 1`.
  - The result is truncated to 10 bits.
- If the ball is already at a bound and the key pushes further, the step still commits (position unchanged), with `blocked = 1` and `step_done` pulsed.
- Only one axis moves per step; diagonal motion does not exist.

## Timing
- Reset values:
  - State IDLE, `frame_cnt = 0`.
  - `BallX = X_START`, `BallY = Y_START`.
  - `dir = NONE`, `blocked = 0`, `step_done = 0`.
  - `BallS = SIZE` always.
- Cycle sequence for a qualifying `frame_tick` sampled at edge t:
  - State is EVAL in cycle t+1.
  - State is COMMIT in cycle t+2.
  - `BallX`/`BallY`/`blocked` hold new values from t+3; `step_done` is high during t+3 only.
  - Latency from tick to position is 3 cycles.
- `frame_tick` arriving in EVAL or COMMIT is dropped: it does not advance `frame_cnt`.
- Changes to `keycode` after the latch edge have no effect until the next step attempt.
- `Reset` in any state takes priority over everything else. It restores all reset values at the next edge and aborts any in-flight step without a `step_done` pulse.
- `frame_tick` and `Reset` in the same cycle: reset wins and the tick is dropped.

## Structure
- Package `ball_pkg` holds:
  - `typedef enum logic [2:0] dir_t` with values NONE=0, LEFT, RIGHT, UP, DOWN.
  - `typedef enum logic [1:0] move_state_t` with values IDLE, EVAL, COMMIT.
  - Keycode constants `KEY_A`, `KEY_D`, `KEY_S`, `KEY_W`.
- Sub-module `key_dir_decode`: combinational mapping from 8-bit keycode to `dir_t`, reused later by the game-state controller.
- The top level holds the FSM, the divider, the candidate/clamp datapath and the output registers.

## Test plan
- Reset with no key, 5 ticks: `BallX = 320`, `BallY = 240`, five `step_done` pulses, `blocked = 0`, `dir = NONE`.
- Hold `keycode = 0x07`, 10 ticks with FRAMES_PER_STEP=1: `BallX = 330` (moves 1 per tick); each update appears 3 cycles after its tick.
- X_START=12, hold `0x04` for 4 ticks: `BallX` goes 11, 10, 10, 10; `blocked` reads 0, 0, 1, 1.
- FRAMES_PER_STEP=4, hold `0x1A` for 8 ticks: exactly 2 `step_done` pulses, `BallY = 238`.
- Change keycode from `0x16` to `0x04` in the cycle after a tick, and issue a second tick during EVAL: that step moves DOWN (`BallY = 241`), the second tick is dropped, and `frame_cnt` is unchanged.
- Assert `Reset` during COMMIT: no `step_done` pulse, outputs return to 320/240/NONE/0 on the next cycle.
